// File: rtl/template_match.sv
// Hamming-similarity digit classifier: sweeps ten 1-bit template ROMs against the image buffer and reports the arg-max digit.
// Optional TM_REJECT_EN: winners scoring below REJECT_THR are reported as digit 4'hF.
module template_match #(
  parameter int ADDR_W     = 12,
  parameter int NPIX       = 4096,
  parameter int NUM_TPL    = 10,
  parameter int SCORE_W    = $clog2(NPIX + 1),
  parameter int REJECT_THR = 3500
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  rom_ad,
  output logic               rom_ce,
  output logic               rom_oce,
  output logic               rom_reset,
  input  logic [NUM_TPL-1:0] tpl_bits,
  output logic [ADDR_W-1:0]  img_ad,
  output logic               img_rd,
  input  logic               img_bit,
  output logic [3:0]         best_digit,
  output logic [SCORE_W-1:0] best_score
);

  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, ARGMAX, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [3:0]        LAST_IDX  = 4'(NUM_TPL - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                valid_q;
  logic [SCORE_W-1:0]  cnt_q [NUM_TPL];
  logic [SCORE_W-1:0]  cnt_d [NUM_TPL];
  logic [3:0]          idx_q, idx_d;
  logic [SCORE_W-1:0]  bestS_q, bestS_d;
  logic [3:0]          bestI_q, bestI_d;
  logic [3:0]          bestDigit_q, bestDigit_d;
  logic [SCORE_W-1:0]  bestScore_q, bestScore_d;
  logic [SCORE_W-1:0]  cand;
  logic [SCORE_W-1:0]  nextS;
  logic [3:0]          nextI;

`ifdef TM_REJECT_EN
  localparam logic [SCORE_W-1:0] REJECT_S = SCORE_W'(REJECT_THR);
`else
  logic [SCORE_W-1:0] unused_rejectThr;
  assign unused_rejectThr = SCORE_W'(REJECT_THR);
`endif

  always_comb begin
    cand = '0;
    for (int t = 0; t < NUM_TPL; t++) begin
      if (idx_q == t[3:0]) cand = cnt_q[t];
    end
    nextS = bestS_q;
    nextI = bestI_q;
    if (cand > bestS_q) begin
      nextS = cand;
      nextI = idx_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    idx_d       = idx_q;
    bestS_d     = bestS_q;
    bestI_d     = bestI_q;
    bestDigit_d = bestDigit_q;
    bestScore_d = bestScore_q;
    cnt_d       = cnt_q;
    if (valid_q) begin
      for (int t = 0; t < NUM_TPL; t++) begin
        if (tpl_bits[t] == img_bit) cnt_d[t] = cnt_q[t] + SCORE_W'(1);
      end
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          addr_d  = '0;
          bestS_d = '0;
          bestI_d = '0;
          for (int t = 0; t < NUM_TPL; t++) cnt_d[t] = '0;
        end
      end
      SCAN: begin
        if (addr_q == LAST_ADDR) begin
          state_d = DRAIN;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        state_d = ARGMAX;
        idx_d   = '0;
      end
      ARGMAX: begin
        // Results are loaded on entry to DONE so they are valid alongside the done pulse.
        bestS_d = nextS;
        bestI_d = nextI;
        if (idx_q == LAST_IDX) begin
          state_d     = DONE;
          bestScore_d = nextS;
          bestDigit_d = nextI;
`ifdef TM_REJECT_EN
          if (nextS < REJECT_S) bestDigit_d = 4'hF;
`endif
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      valid_q     <= 1'b0;
      idx_q       <= '0;
      bestS_q     <= '0;
      bestI_q     <= '0;
      bestDigit_q <= '0;
      bestScore_q <= '0;
      for (int t = 0; t < NUM_TPL; t++) cnt_q[t] <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      valid_q     <= (state_q == SCAN);
      idx_q       <= idx_d;
      bestS_q     <= bestS_d;
      bestI_q     <= bestI_d;
      bestDigit_q <= bestDigit_d;
      bestScore_q <= bestScore_d;
      cnt_q       <= cnt_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign rom_ce     = (state_q == SCAN);
  assign rom_ad     = addr_q;
  assign img_ad     = addr_q;
  assign img_rd     = rom_ce;
  assign rom_oce    = 1'b1;
  assign rom_reset  = 1'b0;
  assign best_digit = bestDigit_q;
  assign best_score = bestScore_q;

endmodule
